// File: rtl/uart_apb_master_if.sv
// Command/response and APB bundle for the UART APB initiator.
// master = initiator side, slave = requester + APB target side.
interface uart_apb_master_if #(
  parameter int ADDR_WD = 12
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [ADDR_WD-1:0] cmd_addr;
  logic [31:0]        cmd_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic               rsp_tmo;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [ADDR_WD-1:0] paddr;
  logic [31:0]        pwdata;
  logic [31:0]        prdata;
  logic               pready;
  logic               pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/uart_apb_master.sv
// APB3 initiator: one outstanding command -> one SETUP/ACCESS transfer.
// Handles wait states, slave errors and an optional ACCESS timeout.
module uart_apb_master #(
  parameter int ADDR_WD     = 12,
  parameter int TIMEOUT_CYC = 255
) (
  input logic               pclk,
  input logic               preset_n,
  uart_apb_master_if.master bus
);

  localparam int CW_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW     = (CW_RAW > 0) ? CW_RAW : 1;
  localparam int LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CW-1:0] TMO_LAST = CW'(LAST_I);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam bit TMO_EN = (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          tmo_hit;

  assign bus.cmd_ready = (state == IDLE) & preset_n;
  assign tmo_hit = TMO_EN && (cnt == TMO_LAST);

  // Transfer sequencer; every APB and response output is a register here.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_tmo   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.pwrite <= bus.cmd_write;
            bus.paddr  <= ADDR_WD'(bus.cmd_addr);
            bus.pwdata <= bus.cmd_wdata;
            bus.psel   <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= bus.pwrite ? 32'd0 : bus.prdata;
            bus.rsp_err   <= bus.pslverr;
            bus.rsp_tmo   <= 1'b0;
            cnt           <= '0;
            state         <= RESP;
          end else if (tmo_hit) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_tmo   <= 1'b1;
            cnt           <= '0;
            state         <= RESP;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_master.sv
// Scoreboard bench for uart_apb_master with a task-driven APB target.
// Built with TIMEOUT_CYC=4 so the abort path is short.
module tb_uart_apb_master;
  localparam int AW  = 12;
  localparam int TMO = 4;

  logic pclk = 1'b0;
  logic preset_n;

  always #5 pclk = ~pclk;

  uart_apb_master_if #(.ADDR_WD(AW)) bus ();

  uart_apb_master #(
    .ADDR_WD    (AW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .pclk    (pclk),
    .preset_n(preset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   compared;
  int   mismatched;

  task automatic run_xfer(input logic w, input logic [AW-1:0] a,
                          input logic [31:0] d, input int nwait,
                          input logic [31:0] rd, input logic se);
    exp_t e;
    int   acc;
    bit   tmo;
    bit   done;
    tmo     = (TMO > 0) && (nwait >= TMO);
    e.rdata = (w || tmo) ? 32'd0 : rd;
    e.err   = tmo ? 1'b1 : se;
    e.tmo   = tmo;
    e.acc   = tmo ? TMO : nwait + 1;
    sb.push_back(e);
    compared++;
    if (bus.cmd_ready !== 1'b1) begin
      $display("FAIL cmd_ready_idle got=%b want=1", bus.cmd_ready);
      mismatched++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    bus.cmd_write = ~w;
    bus.cmd_addr  = ~a;
    bus.cmd_wdata = ~d;
    bus.pready    = 1'b1;
    bus.pslverr   = 1'b1;
    compared++;
    if ({bus.psel, bus.penable, bus.cmd_ready} !== 3'b100) begin
      $display("FAIL setup_phase got psel/pen/crdy=%b want=100",
               {bus.psel, bus.penable, bus.cmd_ready});
      mismatched++;
    end
    @(negedge pclk);
    acc = 0;
    while (bus.penable === 1'b1 && acc < 20) begin
      acc++;
      compared++;
      if ({bus.psel, bus.pwrite, bus.paddr, bus.pwdata} !== {1'b1, w, a, d}) begin
        $display("FAIL access_hold got sel=%b wr=%b a=%h d=%h want 1 %b %h %h",
                 bus.psel, bus.pwrite, bus.paddr, bus.pwdata, w, a, d);
        mismatched++;
      end
      done        = (acc - 1 == nwait);
      bus.pready  = done;
      bus.prdata  = done ? rd : $urandom;
      bus.pslverr = done ? se : 1'b1;
      @(negedge pclk);
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    compared++;
    if (acc != e.acc) begin
      $display("FAIL access_cycles got=%0d want=%0d", acc, e.acc);
      mismatched++;
    end
    compared++;
    if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b001) begin
      $display("FAIL resp_phase got sel/pen/rv=%b want=001",
               {bus.psel, bus.penable, bus.rsp_valid});
      mismatched++;
    end
  endtask

  task automatic take_rsp(input int hold);
    exp_t e;
    int   w8;
    w8 = 0;
    while (bus.rsp_valid !== 1'b1 && w8 < 10) begin
      @(negedge pclk);
      w8++;
    end
    compared++;
    if (bus.rsp_valid !== 1'b1 || sb.size() == 0) begin
      $display("FAIL rsp_arrival rsp_valid=%b queued=%0d want 1 and >0",
               bus.rsp_valid, sb.size());
      mismatched++;
      return;
    end
    e = sb.pop_front();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge pclk);
      compared++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_tmo,
           bus.cmd_ready, bus.psel} !== {1'b1, e.rdata, e.err, e.tmo, 2'b00}) begin
        $display("FAIL rsp_hold cyc=%0d got v=%b d=%h e=%b t=%b cr=%b ps=%b want 1 %h %b %b 0 0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_tmo,
                 bus.cmd_ready, bus.psel, e.rdata, e.err, e.tmo);
        mismatched++;
      end
    end
    compared++;
    if (bus.rsp_rdata !== e.rdata) begin
      $display("FAIL rsp_rdata got=%h want=%h", bus.rsp_rdata, e.rdata);
      mismatched++;
    end
    compared++;
    if ({bus.rsp_err, bus.rsp_tmo} !== {e.err, e.tmo}) begin
      $display("FAIL rsp_status got err/tmo=%b%b want=%b%b",
               bus.rsp_err, bus.rsp_tmo, e.err, e.tmo);
      mismatched++;
    end
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    compared++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
      $display("FAIL rsp_release got rv/cr=%b want=01",
               {bus.rsp_valid, bus.cmd_ready});
      mismatched++;
    end
  endtask

  task automatic test_reset();
    preset_n      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    repeat (3) @(negedge pclk);
    compared++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
         bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_tmo,
         bus.cmd_ready} !== '0) begin
      $display("FAIL reset_outputs got=%h want=0",
               {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
                bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_tmo,
                bus.cmd_ready});
      mismatched++;
    end
    preset_n = 1'b1;
    @(negedge pclk);
    compared++;
    if (bus.cmd_ready !== 1'b1) begin
      $display("FAIL reset_release cmd_ready got=%b want=1", bus.cmd_ready);
      mismatched++;
    end
  endtask

  task automatic test_write_zero_wait();
    run_xfer(1'b1, 12'h00C, 32'h0000_00A5, 0, 32'hFFFF_0000, 1'b0);
    take_rsp(0);
  endtask

  task automatic test_read_wait();
    run_xfer(1'b0, 12'h004, 32'h0, 3, 32'h1234_5678, 1'b0);
    take_rsp(0);
  endtask

  task automatic test_slverr();
    run_xfer(1'b0, 12'h008, 32'h0, 0, 32'hDEAD_BEEF, 1'b1);
    take_rsp(0);
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 12'h010, 32'h0, 100, 32'h7777_7777, 1'b0);
    take_rsp(0);
    run_xfer(1'b1, 12'h014, 32'h0000_0055, 1, 32'h0, 1'b0);
    take_rsp(0);
  endtask

  task automatic test_backpressure();
    run_xfer(1'b0, 12'h018, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
    take_rsp(5);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [31:0]   d;
    for (int i = 0; i < 6; i++) begin
      a = AW'($urandom);
      d = $urandom;
      run_xfer(1'(i % 2), a, d, $urandom_range(0, 2), $urandom, 1'(i == 3));
      take_rsp(0);
    end
  endtask

  task automatic test_reset_mid();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 12'h020;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    @(negedge pclk);
    #2 preset_n = 1'b0;
    #1;
    compared++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0000) begin
      $display("FAIL async_reset got sel/pen/rv/cr=%b want=0000",
               {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready});
      mismatched++;
    end
    @(negedge pclk);
    preset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      compared++;
      if ({bus.rsp_valid, bus.cmd_ready, bus.psel} !== 3'b010) begin
        $display("FAIL post_reset cyc=%0d got rv/cr/sel=%b want=010",
                 i, {bus.rsp_valid, bus.cmd_ready, bus.psel});
        mismatched++;
      end
    end
    run_xfer(1'b0, 12'h024, 32'h0, 0, 32'hA5A5_5A5A, 1'b0);
    take_rsp(0);
    compared++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
      mismatched++;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
